if_fetch: RTL

- Instruction-fetch stage. Owns the PC and a single-outstanding instruction-bus master with a one-entry fetched-instruction buffer.
- Presents if_pc/if_inst to the IF/ID pipeline register.
- Asserts stallreq_o toward the pipeline controller while no instruction is available.
- Handles delay-slot branch redirect and exception flush: flush redirects to new_pc and discards in-flight data.

---
 rtl/if_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding
// instruction-bus master and holds one fetched instruction for IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic [31:0] ibus_data_i,
    input  logic        ibus_ack_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic        pending_reg, pending_next;
    logic        buf_valid_reg, buf_valid_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic        req_reg, req_next;
    logic [31:0] addr_reg, addr_next;

    logic consume;
    logic branch_acc;
    logic wrong_path;
    logic issue;

    // Only the PC, IF and ID stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:3];

    assign consume    = buf_valid_reg & ~stall[1] & ~flush;
    assign branch_acc = branch_flag_i & ~stall[2] & ~flush;
    // Buffer already holds the delay slot, so anything fetched from pc_reg is wrong-path.
    assign wrong_path = branch_acc & buf_valid_reg;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            target_reg    <= 32'h0;
            pending_reg   <= 1'b0;
            buf_valid_reg <= 1'b0;
            buf_pc_reg    <= 32'h0;
            buf_inst_reg  <= 32'h0;
            req_reg       <= 1'b0;
            addr_reg      <= 32'h0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            target_reg    <= target_next;
            pending_reg   <= pending_next;
            buf_valid_reg <= buf_valid_next;
            buf_pc_reg    <= buf_pc_next;
            buf_inst_reg  <= buf_inst_next;
            req_reg       <= req_next;
            addr_reg      <= addr_next;
        end
    end

    // Next-state: bus FSM, buffer fill/consume, PC sequencing, branch and flush redirect.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        target_next    = target_reg;
        pending_next   = pending_reg;
        buf_valid_next = buf_valid_reg;
        buf_pc_next    = buf_pc_reg;
        buf_inst_next  = buf_inst_reg;
        req_next       = req_reg;
        addr_next      = addr_reg;
        issue          = 1'b0;

        if (consume) begin
            buf_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                issue = ~flush & ~stall[0] & (~buf_valid_reg | consume);
            end
            BUSY: begin
                if (ibus_ack_i) begin
                    req_next   = 1'b0;
                    addr_next  = 32'h0;
                    state_next = IDLE;
                    if (~flush & ~wrong_path) begin
                        buf_pc_next    = addr_reg;
                        buf_inst_next  = ibus_data_i;
                        buf_valid_next = 1'b1;
                    end
                end else if (flush | wrong_path) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (ibus_ack_i) begin
                    req_next   = 1'b0;
                    addr_next  = 32'h0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (issue) begin
            req_next  = 1'b1;
            addr_next = pc_reg;
            if (wrong_path) begin
                // Request goes out but its data is thrown away; fetch resumes at the target.
                pc_next    = branch_target_address_i;
                state_next = DISCARD;
            end else begin
                state_next = BUSY;
                if (branch_acc) begin
                    // This issue is the delay slot; the following fetch is the target.
                    pc_next      = branch_target_address_i;
                    pending_next = 1'b0;
                end else if (pending_reg) begin
                    pc_next      = target_reg;
                    pending_next = 1'b0;
                end else begin
                    pc_next = pc_reg + 32'd4;
                end
            end
        end else if (branch_acc) begin
            if (buf_valid_reg || state_reg == BUSY) begin
                // Delay slot is buffered or in flight: next fetch is the target.
                pc_next = branch_target_address_i;
            end else begin
                // Delay slot still has to be fetched from pc_reg; remember the target.
                target_next  = branch_target_address_i;
                pending_next = 1'b1;
            end
        end

        if (flush) begin
            pc_next        = new_pc;
            buf_valid_next = 1'b0;
            pending_next   = 1'b0;
        end
    end

    assign ibus_req_o  = req_reg;
    assign ibus_addr_o = addr_reg;
    assign if_pc       = buf_valid_reg ? buf_pc_reg : 32'h0;
    assign if_inst     = buf_valid_reg ? buf_inst_reg : 32'h0;
    assign stallreq_o  = ~buf_valid_reg & ~flush;

endmodule
